// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - APB config/result register bank feeding the ECC core
// Define APB_STRICT_DECODE_EN to reject accesses with non-zero upper or misaligned address bits.
module apb_reg_bank #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PENABLE,
    input  logic                       PSEL,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       core_start,
    output logic [1:0]                 ctrl,
    output logic [AMBA_WORD-1:0]       data_in,
    output logic [1:0]                 codeword_width,
    output logic [AMBA_WORD-1:0]       noise,
    input  logic                       core_done,
    input  logic [AMBA_WORD-1:0]       core_data_out,
    input  logic [1:0]                 core_num_of_errors,
    output logic                       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_DIN    = 3'd1;
    localparam logic [2:0] A_CWW    = 3'd2;
    localparam logic [2:0] A_NOISE  = 3'd3;
    localparam logic [2:0] A_DOUT   = 3'd4;
    localparam logic [2:0] A_NERR   = 3'd5;

    // state_q records the bus phase of the cycle that just ended
    apb_state_e state_q, state_d;

    logic [1:0]           ctrl_q, ctrl_d;
    logic [AMBA_WORD-1:0] data_in_q, data_in_d;
    logic [1:0]           cww_q, cww_d;
    logic [AMBA_WORD-1:0] noise_q, noise_d;
    logic [AMBA_WORD-1:0] data_out_q, data_out_d;
    logic [1:0]           nerr_q, nerr_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic [AMBA_WORD-1:0] prdata_q, prdata_d;

    logic [2:0]           reg_sel;
    logic                 addr_ok;
    logic                 wr_en;
    logic                 cfg_wr;
    logic                 rd_load;
    logic [AMBA_WORD-1:0] rd_mux;

    assign reg_sel = PADDR[4:2];

`ifdef APB_STRICT_DECODE_EN
    assign addr_ok = (PADDR[AMBA_ADDR_WIDTH-1:5] == '0) && (PADDR[1:0] == 2'b00);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};
    assign addr_ok          = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (PSEL && PENABLE)       state_d = ST_ACCESS;
                else if (PSEL && !PENABLE) state_d = ST_SETUP;
                else                       state_d = ST_IDLE;
            end
            ST_ACCESS: begin
                if (PSEL && !PENABLE) state_d = ST_SETUP;
                else                  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // An access phase only counts if the previous cycle was a setup phase
    always_comb begin
        wr_en   = (state_q == ST_SETUP) && PSEL && PENABLE && PWRITE && addr_ok;
        cfg_wr  = wr_en && !busy_q;
        rd_load = PSEL && !PENABLE && !PWRITE;
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            A_CTRL:  rd_mux = {{(AMBA_WORD-2){1'b0}}, ctrl_q};
            A_DIN:   rd_mux = data_in_q;
            A_CWW:   rd_mux = {{(AMBA_WORD-2){1'b0}}, cww_q};
            A_NOISE: rd_mux = noise_q;
            A_DOUT:  rd_mux = data_out_q;
            A_NERR:  rd_mux = {{(AMBA_WORD-2){1'b0}}, nerr_q};
            default: rd_mux = '0;
        endcase
        if (!addr_ok) rd_mux = '0;
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        data_in_d  = data_in_q;
        cww_d      = cww_q;
        noise_d    = noise_q;
        data_out_d = data_out_q;
        nerr_d     = nerr_q;
        start_d    = 1'b0;
        busy_d     = busy_q;
        prdata_d   = prdata_q;

        if (cfg_wr) begin
            case (reg_sel)
                A_CTRL: begin
                    ctrl_d  = PWDATA[1:0];
                    start_d = (PWDATA[1:0] != 2'b11);
                end
                A_DIN:   data_in_d = PWDATA;
                A_CWW:   cww_d     = PWDATA[1:0];
                A_NOISE: noise_d   = PWDATA;
                default: ;
            endcase
        end

        if (core_done) begin
            data_out_d = core_data_out;
            nerr_d     = core_num_of_errors;
        end

        // A fresh start outranks a stray done arriving while idle
        if (start_d)        busy_d = 1'b1;
        else if (core_done) busy_d = 1'b0;

        if (rd_load) prdata_d = rd_mux;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            data_in_q  <= '0;
            cww_q      <= '0;
            noise_q    <= '0;
            data_out_q <= '0;
            nerr_q     <= '0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            prdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            data_in_q  <= data_in_d;
            cww_q      <= cww_d;
            noise_q    <= noise_d;
            data_out_q <= data_out_d;
            nerr_q     <= nerr_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            prdata_q   <= prdata_d;
        end
    end

    assign PRDATA         = prdata_q;
    assign core_start     = start_q;
    assign ctrl           = ctrl_q;
    assign data_in        = data_in_q;
    assign codeword_width = cww_q;
    assign noise          = noise_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// tb/tb_apb_reg_bank.sv - scoreboard bench for apb_reg_bank
module tb_apb_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] PADDR;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [31:0] PRDATA;
    logic        core_start;
    logic [1:0]  ctrl;
    logic [31:0] data_in;
    logic [1:0]  codeword_width;
    logic [31:0] noise;
    logic        core_done;
    logic [31:0] core_data_out;
    logic [1:0]  core_num_of_errors;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    apb_reg_bank #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL),
        .PWDATA(PWDATA), .PWRITE(PWRITE), .PRDATA(PRDATA), .core_start(core_start),
        .ctrl(ctrl), .data_in(data_in), .codeword_width(codeword_width), .noise(noise),
        .core_done(core_done), .core_data_out(core_data_out),
        .core_num_of_errors(core_num_of_errors), .busy(busy)
    );

    task automatic bus_write(input logic [19:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic bus_read(input logic [19:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(negedge clk);
        d = PRDATA;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pulse_done(input logic [31:0] d, input logic [1:0] e);
        @(posedge clk); #1;
        core_done = 1'b1; core_data_out = d; core_num_of_errors = e;
        @(posedge clk); #1;
        core_done = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] got, exp;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({core_start, busy, PRDATA, ctrl, data_in, codeword_width, noise} !== '0) begin
            failures++;
            $display("FAIL reset_outputs start=%b busy=%b prdata=%h ctrl=%h din=%h cww=%h noise=%h exp all 0",
                     core_start, busy, PRDATA, ctrl, data_in, codeword_width, noise);
        end
        #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'h0);
            bus_read(20'(i * 4), got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_read[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_config;
        logic [31:0] got, exp;
        logic [19:0] addrs [3] = '{20'h04, 20'h0C, 20'h08};
        logic [31:0] vals  [3] = '{32'hDEADBEEF, 32'h00000010, 32'h00000002};
        for (int i = 0; i < 3; i++) begin
            bus_write(addrs[i], vals[i]);
            checks++;
            if (core_start !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL config_no_start[%0d] start=%b busy=%b exp 0 0", i, core_start, busy);
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(vals[i]);
            bus_read(addrs[i], got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL config_read[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        checks++;
        if (data_in !== 32'hDEADBEEF || noise !== 32'h10 || codeword_width !== 2'd2) begin
            failures++;
            $display("FAIL config_ports din=%h noise=%h cww=%h exp deadbeef 10 2", data_in, noise, codeword_width);
        end
    endtask

    task automatic test_ctrl_reserved;
        logic [31:0] got, exp;
        bus_write(20'h00, 32'hFFFFFFFF);
        checks++;
        if (core_start !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reserved_no_start start=%b busy=%b exp 0 0", core_start, busy);
        end
        exp_q.push_back(32'h3);
        bus_read(20'h00, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reserved_ctrl_read got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_core;
        logic [31:0] got, exp;
        logic [19:0] addrs [6] = '{20'h10, 20'h14, 20'h04, 20'h00, 20'h18, 20'h1C};
        bus_write(20'h00, 32'h1);
        checks++;
        if (core_start !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL core_start_pulse start=%b busy=%b exp 1 1", core_start, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (core_start !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL core_start_width start=%b busy=%b exp 0 1", core_start, busy);
        end
        bus_write(20'h04, 32'h1234);
        pulse_done(32'hA5, 2'd1);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL core_busy_clear busy=%b exp 0", busy);
        end
        bus_write(20'h10, 32'h1111);
        exp_q.push_back(32'hA5);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 6; i++) begin
            bus_read(addrs[i], got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL core_read[%0d] addr=%h got=%h exp=%h", i, addrs[i], got, exp);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] got, exp;
        bus_write(20'h00, 32'h0);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 20'h10;
        core_done = 1'b1; core_data_out = 32'h77; core_num_of_errors = 2'd2;
        exp_q.push_back(32'hA5);
        @(posedge clk); #1;
        PENABLE = 1'b1; core_done = 1'b0;
        @(negedge clk);
        got = PRDATA;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL simul_old_dout got=%h exp=%h", got, exp);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL simul_busy busy=%b exp 0", busy);
        end
        exp_q.push_back(32'h77);
        bus_read(20'h10, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL simul_new_dout got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got, exp;
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h00; PWDATA = 32'h2;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 20'h00;
        exp_q.push_back(32'h2);
        checks++;
        if (core_start !== 1'b1) begin
            failures++;
            $display("FAIL b2b_start start=%b exp 1", core_start);
        end
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(negedge clk);
        got = PRDATA;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL b2b_read got=%h exp=%h", got, exp);
        end
        pulse_done(32'h3C, 2'd0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_clear busy=%b exp 0", busy);
        end
    endtask

    task automatic test_no_setup;
        logic [31:0] got, exp;
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 20'h04; PWDATA = 32'hFF;
        repeat (2) @(posedge clk);
        #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        checks++;
        if (data_in !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL nosetup_port din=%h exp deadbeef", data_in);
        end
        exp_q.push_back(32'hDEADBEEF);
        bus_read(20'h04, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL nosetup_read got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_alias;
        logic [31:0] got, exp;
        logic [31:0] exp_din;
`ifdef APB_STRICT_DECODE_EN
        exp_din = 32'hDEADBEEF;
        exp_q.push_back(32'h0);
`else
        exp_din = 32'h55;
        exp_q.push_back(32'h55);
`endif
        bus_write(20'h20004, 32'h55);
        bus_read(20'h20004, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL alias_read got=%h exp=%h", got, exp);
        end
        checks++;
        if (data_in !== exp_din) begin
            failures++;
            $display("FAIL alias_port din=%h exp=%h", data_in, exp_din);
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h04; PWDATA = 32'h99;
        @(posedge clk); #1;
        PENABLE = 1'b1; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge clk);
        checks++;
        if (data_in !== 32'h0 || busy !== 1'b0 || PRDATA !== 32'h0 || core_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid din=%h busy=%b prdata=%h start=%b exp 0", data_in, busy, PRDATA, core_start);
        end
    endtask

    initial begin
        rst = 1'b0; PADDR = '0; PENABLE = 1'b0; PSEL = 1'b0; PWDATA = '0; PWRITE = 1'b0;
        core_done = 1'b0; core_data_out = '0; core_num_of_errors = '0;
        test_reset();
        test_config();
        test_ctrl_reserved();
        test_core();
        test_simultaneous();
        test_back_to_back();
        test_no_setup();
        test_alias();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
